dma_copy_engine: RTL and testbench
==================================

DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

Interface
REQ-001 Parameter SDATA_BASE, default 16'hA000, base byte address of the protected secure-data window.
REQ-002 Parameter SDATA_SIZE, default 16'h1000, size in bytes of the protected window.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request pulse; sampled each rising edge.
REQ-006 src_addr  input  16  source byte address; bit 0 ignored.
REQ-007 dst_addr  input  16  destination byte address; bit 0 ignored.
REQ-008 len  input  16  transfer length in 16-bit words.
REQ-009 busy  output  1  high while a transfer is being checked or executed.
REQ-010 done  output  1  one-cycle pulse on successful completion.
REQ-011 err  output  1  sticky error flag; cleared only by an accepted start or reset.
REQ-012 dma_addr  output  16  DMA byte address, bit 0 always 0.
REQ-013 dma_en  output  1  DMA request; held until dma_ready.
REQ-014 dma_we  output  2  byte write enables; 2'b00 read, 2'b11 word write.
REQ-015 dma_din  output  16  write data to memory.
REQ-016 dma_dout  input  16  read data from memory; valid in the cycle dma_ready is high for a read.
REQ-017 dma_ready  input  1  memory accepts/completes current request this cycle.
REQ-018 dma_resp  input  1  error response; qualified by dma_ready.

Function
REQ-019 States: IDLE, CHECK, RD, WR, DONE, ERR.
REQ-020 start accepted only when busy is low (IDLE, DONE, ERR); start while busy is ignored with no effect.
REQ-021 On accept: latch src_addr&16'hFFFE, dst_addr&16'hFFFE, len into internal counters; clear err; enter CHECK next cycle.
REQ-022 CHECK lasts exactly one cycle, issues no DMA request, and is the only place transfers are vetted.
REQ-023 CHECK, len==0: go DONE.
REQ-024 CHECK: ranges [src, src+2*len) and [dst, dst+2*len) computed in 17 bits; if either exceeds 17'h10000 (wrap) or overlaps [SDATA_BASE, SDATA_BASE+SDATA_SIZE), go ERR with no DMA cycle ever issued.
REQ-025 CHECK otherwise: go RD.
REQ-026 RD: dma_en=1, dma_we=2'b00, dma_addr=current src; all held stable until dma_ready.
REQ-027 RD with dma_ready & !dma_resp: capture dma_dout into a one-word buffer, go WR.
REQ-028 WR: dma_en=1, dma_we=2'b11, dma_addr=current dst, dma_din=buffer; held stable until dma_ready.
REQ-029 WR with dma_ready & !dma_resp: src+=2, dst+=2, remaining-=1; if remaining was 1 go DONE else go RD.
REQ-030 RD or WR with dma_ready & dma_resp: go ERR; counters not advanced.
REQ-031 DONE: done=1 for exactly that cycle, then IDLE unless a start is accepted in the same cycle (then CHECK).
REQ-032 ERR: err=1 continuously; remains in ERR until an accepted start.
REQ-033 busy = 1 in CHECK, RD, WR; 0 otherwise.
REQ-034 dma_en=0 outside RD/WR; when dma_en=0, dma_addr, dma_we, dma_din drive zero.
REQ-035 Throughput with dma_ready tied high: 2 cycles per word; start-to-done latency = 2 + 2*len cycles for legal len>0.
REQ-036 dma_ready and dma_resp ignored in IDLE, CHECK, DONE, ERR.

Reset
REQ-037 reset_n low asynchronously forces state IDLE, busy=0, done=0, err=0, dma_en=0, dma_addr=0, dma_we=0, dma_din=0, all counters and buffer zero.
REQ-038 reset_n assertion mid-transfer aborts immediately; no further DMA cycle after release until a new start.
REQ-039 First start is accepted on the first rising edge after reset_n deasserts.

Verification
REQ-040 src=16'h0200, dst=16'h0300, len=3, dma_ready=1, memory preloaded 1111/2222/3333 -> reads 0200/0202/0204, writes 0300/0302/0304 same data, done pulse 8 cycles after start, err=0.
REQ-041 dst=16'h9FFE, len=2 (touches A000) -> ERR after CHECK, err=1, dma_en never asserted; next start with legal args clears err.
REQ-042 src=16'hFFFE, len=2 (wraps) -> ERR, no DMA cycle; len=0 with any addresses -> done pulse 2 cycles after start, no DMA cycle.
REQ-043 dma_ready held low 3 cycles per request -> dma_addr/dma_we/dma_din stable across stall, data correct, start during busy ignored.
REQ-044 dma_resp=1 with dma_ready on second read -> ERR, err=1, busy=0, one write completed only.
REQ-045 reset_n pulsed low during WR of word 2 -> all outputs zero immediately, dma_en stays 0 until next start.

Source files
------------

// File: rtl/dma_copy_engine_if.sv
// Memory-side request/response bus of the DMA copy engine; the engine is the master.
// A request is held on dma_en/dma_addr/dma_we/dma_din until the memory raises dma_ready.
interface dma_copy_engine_if;
  logic [15:0] dma_addr;
  logic        dma_en;
  logic [1:0]  dma_we;
  logic [15:0] dma_din;
  logic [15:0] dma_dout;
  logic        dma_ready;
  logic        dma_resp;

  modport master (
    output dma_addr, dma_en, dma_we, dma_din,
    input  dma_dout, dma_ready, dma_resp
  );

  modport slave (
    input  dma_addr, dma_en, dma_we, dma_din,
    output dma_dout, dma_ready, dma_resp
  );
endinterface

// File: rtl/dma_copy_engine.sv
// Word-by-word memory copy that refuses any transfer touching the secure window; 2 + 2*len cycles
// start-to-done with dma_ready high, each read/write stalls in place until dma_ready.
module dma_copy_engine #(
  parameter logic [15:0] SDATA_BASE = 16'hA000,
  parameter logic [15:0] SDATA_SIZE = 16'h1000
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [15:0]               src_addr,
  input  logic [15:0]               dst_addr,
  input  logic [15:0]               len,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  dma_copy_engine_if.master         dma
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_RD,
    S_WR,
    S_DONE,
    S_ERR
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d;
  logic [15:0] dst_q, dst_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] buf_q, buf_d;

  logic        accept;
  logic [17:0] span;
  logic [17:0] src_end;
  logic [17:0] dst_end;
  logic [17:0] win_lo;
  logic [17:0] win_hi;
  logic        src_bad;
  logic        dst_bad;

  // Range ends carry past 17 bits when both address and length are large, so keep 18.
  always_comb begin
    span    = {1'b0, rem_q, 1'b0};
    src_end = {2'b00, src_q} + span;
    dst_end = {2'b00, dst_q} + span;
    win_lo  = {2'b00, SDATA_BASE};
    win_hi  = win_lo + {2'b00, SDATA_SIZE};
    src_bad = (src_end > 18'h10000) ||
              (({2'b00, src_q} < win_hi) && (src_end > win_lo));
    dst_bad = (dst_end > 18'h10000) ||
              (({2'b00, dst_q} < win_hi) && (dst_end > win_lo));
  end

  assign busy   = (state_q == S_CHECK) || (state_q == S_RD) || (state_q == S_WR);
  assign done   = (state_q == S_DONE);
  assign err    = (state_q == S_ERR);
  assign accept = start && !busy;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    buf_d   = buf_q;

    if (accept) begin
      src_d   = src_addr & 16'hFFFE;
      dst_d   = dst_addr & 16'hFFFE;
      rem_d   = len;
      state_d = S_CHECK;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_CHECK: begin
          if (rem_q == 16'd0) begin
            state_d = S_DONE;
          end else if (src_bad || dst_bad) begin
            state_d = S_ERR;
          end else begin
            state_d = S_RD;
          end
        end
        S_RD: begin
          if (dma.dma_ready) begin
            if (dma.dma_resp) begin
              state_d = S_ERR;
            end else begin
              buf_d   = dma.dma_dout;
              state_d = S_WR;
            end
          end
        end
        S_WR: begin
          if (dma.dma_ready) begin
            if (dma.dma_resp) begin
              state_d = S_ERR;
            end else begin
              src_d   = src_q + 16'd2;
              dst_d   = dst_q + 16'd2;
              rem_d   = rem_q - 16'd1;
              state_d = (rem_q == 16'd1) ? S_DONE : S_RD;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        S_ERR:   state_d = S_ERR;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Bus outputs are decoded from the registered state so they drop the instant reset asserts.
  always_comb begin
    dma.dma_en   = 1'b0;
    dma.dma_addr = 16'h0000;
    dma.dma_we   = 2'b00;
    dma.dma_din  = 16'h0000;
    case (state_q)
      S_RD: begin
        dma.dma_en   = 1'b1;
        dma.dma_addr = src_q;
      end
      S_WR: begin
        dma.dma_en   = 1'b1;
        dma.dma_addr = dst_q;
        dma.dma_we   = 2'b11;
        dma.dma_din  = buf_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      src_q   <= 16'h0000;
      dst_q   <= 16'h0000;
      rem_q   <= 16'h0000;
      buf_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_dma_copy_engine.sv
// Directed bench for dma_copy_engine: scripted memory responder with stall/error injection
// and a bus monitor that logs completed reads and writes.
module tb_dma_copy_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;
  logic [15:0] len;
  logic        busy;
  logic        done;
  logic        err;

  dma_copy_engine_if dma_if ();

  dma_copy_engine dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .src_addr (src_addr),
    .dst_addr (dst_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .dma      (dma_if.master)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  logic ready_tie = 1'b0;
  logic resp_tie  = 1'b0;
  int   stall_n   = 0;
  int   resp_at   = 0;

  int          wait_cnt  = 0;
  int          en_cnt    = 0;
  int          stall_cnt = 0;
  int          unstable  = 0;
  int          n_rd      = 0;
  int          n_wr      = 0;
  logic        stalled_q = 1'b0;
  logic [15:0] prev_addr = '0;
  logic [1:0]  prev_we   = '0;
  logic [15:0] prev_din  = '0;
  logic [15:0] rd_log      [0:63];
  logic [15:0] wr_addr_log [0:63];
  logic [15:0] wr_data_log [0:63];

  assign dma_if.dma_ready = ready_tie | (dma_if.dma_en && (wait_cnt >= stall_n));
  assign dma_if.dma_resp  = resp_tie |
                            (dma_if.dma_en && (dma_if.dma_we == 2'b00) && dma_if.dma_ready &&
                             ((n_rd + 1) == resp_at));

  always_comb begin
    case (dma_if.dma_addr)
      16'h0200: dma_if.dma_dout = 16'h1111;
      16'h0202: dma_if.dma_dout = 16'h2222;
      16'h0204: dma_if.dma_dout = 16'h3333;
      default:  dma_if.dma_dout = dma_if.dma_addr ^ 16'h5A5A;
    endcase
  end

  always @(posedge clk) begin
    if (dma_if.dma_en && !dma_if.dma_ready) wait_cnt <= wait_cnt + 1;
    else                                    wait_cnt <= 0;
    if (dma_if.dma_en) en_cnt <= en_cnt + 1;
    if (dma_if.dma_en && !dma_if.dma_ready) stall_cnt <= stall_cnt + 1;
    if (stalled_q && ((dma_if.dma_addr != prev_addr) || (dma_if.dma_we != prev_we) ||
                      (dma_if.dma_din != prev_din)))
      unstable <= unstable + 1;
    stalled_q <= dma_if.dma_en && !dma_if.dma_ready;
    prev_addr <= dma_if.dma_addr;
    prev_we   <= dma_if.dma_we;
    prev_din  <= dma_if.dma_din;
    if (dma_if.dma_en && dma_if.dma_ready && !dma_if.dma_resp) begin
      if (dma_if.dma_we == 2'b00) begin
        rd_log[n_rd[5:0]] <= dma_if.dma_addr;
        n_rd <= n_rd + 1;
      end else begin
        wr_addr_log[n_wr[5:0]] <= dma_if.dma_addr;
        wr_data_log[n_wr[5:0]] <= dma_if.dma_din;
        n_wr <= n_wr + 1;
      end
    end
  end

  task automatic run(input logic [15:0] s, input logic [15:0] d, input logic [15:0] l,
                     input int maxc, input bit poke, output int lat);
    src_addr = s;
    dst_addr = d;
    len      = l;
    start    = 1'b1;
    lat      = -1;
    for (int k = 1; k <= maxc; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (poke && k == 4) begin
        start    = 1'b1;
        src_addr = 16'hA000;
        len      = 16'd1;
      end
      if (done || err) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int b_rd;
    int b_wr;
    int e0;
    int s0;

    reset_n   = 1'b0;
    start     = 1'b0;
    src_addr  = '0;
    dst_addr  = '0;
    len       = '0;
    ready_tie = 1'b1;
    resp_tie  = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_en", dma_if.dma_en, 1'b0);
    check("rst_addr", dma_if.dma_addr, 16'h0000);
    check("rst_we", dma_if.dma_we, 2'b00);
    check("rst_din", dma_if.dma_din, 16'h0000);
    ready_tie = 1'b0;
    resp_tie  = 1'b0;

    reset_n = 1'b1;
    b_rd = n_rd;
    b_wr = n_wr;
    run(16'h0200, 16'h0300, 16'd3, 20, 1'b0, lat);
    check("copy_latency", lat, 8);
    check("copy_done", done, 1'b1);
    check("copy_err", err, 1'b0);
    check("copy_nrd", n_rd - b_rd, 3);
    check("copy_rd0", rd_log[b_rd], 16'h0200);
    check("copy_rd1", rd_log[b_rd + 1], 16'h0202);
    check("copy_rd2", rd_log[b_rd + 2], 16'h0204);
    check("copy_nwr", n_wr - b_wr, 3);
    check("copy_wa0", wr_addr_log[b_wr], 16'h0300);
    check("copy_wa2", wr_addr_log[b_wr + 2], 16'h0304);
    check("copy_wd0", wr_data_log[b_wr], 16'h1111);
    check("copy_wd1", wr_data_log[b_wr + 1], 16'h2222);
    check("copy_wd2", wr_data_log[b_wr + 2], 16'h3333);
    @(negedge clk);
    check("done_one_cycle", done, 1'b0);
    check("idle_busy", busy, 1'b0);

    e0 = en_cnt;
    run(16'h0200, 16'h9FFE, 16'd2, 10, 1'b0, lat);
    check("win_latency", lat, 2);
    check("win_err", err, 1'b1);
    check("win_done", done, 1'b0);
    ready_tie = 1'b1;
    resp_tie  = 1'b1;
    repeat (3) @(negedge clk);
    check("err_sticky", err, 1'b1);
    check("err_busy", busy, 1'b0);
    check("win_no_dma", en_cnt - e0, 0);
    ready_tie = 1'b0;
    resp_tie  = 1'b0;

    b_wr = n_wr;
    run(16'h0400, 16'h0500, 16'd1, 10, 1'b0, lat);
    check("clear_latency", lat, 4);
    check("clear_err", err, 1'b0);
    check("clear_wa", wr_addr_log[b_wr], 16'h0500);
    check("clear_wd", wr_data_log[b_wr], 16'h5E5A);

    e0 = en_cnt;
    run(16'hFFFE, 16'h0600, 16'd2, 10, 1'b0, lat);
    check("wrap_latency", lat, 2);
    check("wrap_err", err, 1'b1);
    check("wrap_no_dma", en_cnt - e0, 0);
    b_wr = n_wr;
    run(16'hFFFE, 16'h0600, 16'd1, 10, 1'b0, lat);
    check("top_latency", lat, 4);
    check("top_err", err, 1'b0);
    check("top_wd", wr_data_log[b_wr], 16'hA5A4);

    e0 = en_cnt;
    run(16'hA000, 16'hA002, 16'd0, 10, 1'b0, lat);
    check("len0_latency", lat, 2);
    check("len0_done", done, 1'b1);
    check("len0_no_dma", en_cnt - e0, 0);

    run(16'h9FFC, 16'hB000, 16'd2, 10, 1'b0, lat);
    check("edge_ok_latency", lat, 6);
    check("edge_ok_err", err, 1'b0);
    run(16'h0200, 16'hAFFE, 16'd1, 10, 1'b0, lat);
    check("last_word_latency", lat, 2);
    check("last_word_err", err, 1'b1);

    stall_n = 3;
    s0   = stall_cnt;
    b_rd = n_rd;
    b_wr = n_wr;
    run(16'h0201, 16'h0701, 16'd3, 60, 1'b1, lat);
    check("stall_latency", lat, 26);
    check("stall_err", err, 1'b0);
    check("stall_stable", unstable, 0);
    check("stall_cycles", stall_cnt - s0, 18);
    check("stall_rd0", rd_log[b_rd], 16'h0200);
    check("stall_wa2", wr_addr_log[b_wr + 2], 16'h0704);
    check("stall_wd0", wr_data_log[b_wr], 16'h1111);
    check("stall_wd2", wr_data_log[b_wr + 2], 16'h3333);
    stall_n = 0;

    b_rd    = n_rd;
    b_wr    = n_wr;
    resp_at = n_rd + 2;
    run(16'h0200, 16'h0800, 16'd3, 20, 1'b0, lat);
    check("resp_latency", lat, 5);
    check("resp_err", err, 1'b1);
    check("resp_busy", busy, 1'b0);
    check("resp_nwr", n_wr - b_wr, 1);
    check("resp_nrd", n_rd - b_rd, 1);
    check("resp_wd0", wr_data_log[b_wr], 16'h1111);
    resp_at = 0;

    b_wr     = n_wr;
    src_addr = 16'h0200;
    dst_addr = 16'h0900;
    len      = 16'd3;
    start    = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst_we", dma_if.dma_we, 2'b11);
    check("pre_rst_addr", dma_if.dma_addr, 16'h0902);
    reset_n = 1'b0;
    #1;
    check("mid_rst_en", dma_if.dma_en, 1'b0);
    check("mid_rst_addr", dma_if.dma_addr, 16'h0000);
    check("mid_rst_we", dma_if.dma_we, 2'b00);
    check("mid_rst_din", dma_if.dma_din, 16'h0000);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_err", err, 1'b0);
    e0 = en_cnt;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_rst_no_dma", en_cnt - e0, 0);
    check("post_rst_nwr", n_wr - b_wr, 1);
    run(16'h0200, 16'h0A00, 16'd1, 10, 1'b0, lat);
    check("recover_latency", lat, 4);
    check("recover_err", err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
